// File: rtl/pix_event_arbiter_rr.sv
// Pixel event capture with two-level round-robin arbitration (group, then pixel),
// per-group burst quota, timestamped AER words through a valid/ready output FIFO.
module pix_event_arbiter_rr #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int GRP        = 4,
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BURST  = 16,
  localparam int RA = $clog2(ROWS),
  localparam int CA = $clog2(COLS),
  localparam int DW = RA + CA + TS_WIDTH + 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [ROWS*COLS*2-1:0]   set_i,
  output logic [ROWS*COLS-1:0]     gnt_o,
  output logic                     grp_release_o,
  output logic [DW-1:0]            data_out_o,
  output logic                     data_valid_o,
  input  logic                     data_ready_i,
  output logic [15:0]              drop_cnt_o,
  output logic                     busy_o
);

  localparam int NPIX = ROWS * COLS;
  localparam int PW   = $clog2(NPIX);
  localparam int GC   = COLS / GRP;
  localparam int NG   = (ROWS / GRP) * GC;
  localparam int PPG  = GRP * GRP;
  localparam int GW   = (NG > 1) ? $clog2(NG) : 1;
  localparam int LW   = (PPG > 1) ? $clog2(PPG) : 1;
  localparam int BW   = $clog2(MAX_BURST + 1);
  localparam int FW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = FW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GSEL  = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NPIX-1:0]     pend_q, pend_d, pol_q, pol_d;
  logic [GW-1:0]       grp_ptr_q, grp_ptr_d, cur_grp_q, cur_grp_d;
  logic [LW-1:0]       pix_ptr_q [NG];
  logic [LW-1:0]       pix_ptr_d [NG];
  logic [BW-1:0]       burst_q, burst_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [15:0]         drop_q, drop_d;
  logic [DW-1:0]       mem_q [FIFO_DEPTH];
  logic [DW-1:0]       mem_d [FIFO_DEPTH];
  logic [FW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [NG-1:0]       grp_any;
  logic [PPG-1:0]      cur_pend;
  logic                grp_found, pix_found;
  logic [GW-1:0]       sel_grp;
  logic [LW-1:0]       sel_pix;
  logic                fifo_full, fifo_empty, tenure_end, grant_en, push, pop;
  logic [PW-1:0]       gnt_idx;
  logic [NPIX-1:0]     gnt_vec;
  logic [DW-1:0]       gnt_word;

  // Groups and in-group pixels are both numbered in raster order.
  function automatic int pix_of(input int g, input int l);
    return ((g / GC) * GRP + l / GRP) * COLS + (g % GC) * GRP + l % GRP;
  endfunction

  always_comb begin
    int idx;
    idx       = 0;
    grp_any   = {NG{1'b0}};
    cur_pend  = {PPG{1'b0}};
    grp_found = 1'b0;
    sel_grp   = {GW{1'b0}};
    pix_found = 1'b0;
    sel_pix   = {LW{1'b0}};
    for (int g = 0; g < NG; g++) begin
      for (int l = 0; l < PPG; l++) begin
        grp_any[g] = grp_any[g] | pend_q[PW'(pix_of(g, l))];
      end
    end
    for (int l = 0; l < PPG; l++) begin
      cur_pend[l] = pend_q[PW'(pix_of(int'(cur_grp_q), l))];
    end
    for (int i = 0; i < NG; i++) begin
      idx = (int'(grp_ptr_q) + i) % NG;
      if (!grp_found && grp_any[GW'(idx)]) begin
        grp_found = 1'b1;
        sel_grp   = GW'(idx);
      end else begin
        grp_found = grp_found;
      end
    end
    for (int i = 0; i < PPG; i++) begin
      idx = (int'(pix_ptr_q[cur_grp_q]) + i) % PPG;
      if (!pix_found && cur_pend[LW'(idx)]) begin
        pix_found = 1'b1;
        sel_pix   = LW'(idx);
      end else begin
        pix_found = pix_found;
      end
    end
  end

  // Release takes priority over granting; a full FIFO simply stalls the tenure.
  always_comb begin
    fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
    fifo_empty = (cnt_q == {CW{1'b0}});
    tenure_end = (state_q == ST_SERVE) && (!(|cur_pend) || (burst_q == BW'(MAX_BURST)));
    grant_en   = (state_q == ST_SERVE) && !tenure_end && !fifo_full && pix_found;
    gnt_idx    = PW'(pix_of(int'(cur_grp_q), int'(sel_pix)));
    gnt_vec    = {NPIX{1'b0}};
    if (grant_en) begin
      gnt_vec[gnt_idx] = 1'b1;
    end else begin
      gnt_vec = {NPIX{1'b0}};
    end
    gnt_word = {RA'(int'(gnt_idx) / COLS), CA'(int'(gnt_idx) % COLS), ts_q, pol_q[gnt_idx]};
  end

  // A pixel granted this cycle may be re-armed by a new event; others pending drop it.
  always_comb begin
    int ndrop;
    int dsum;
    ndrop  = 0;
    pend_d = pend_q;
    pol_d  = pol_q;
    for (int p = 0; p < NPIX; p++) begin
      if (gnt_vec[p]) begin
        pend_d[p] = |set_i[2*p +: 2];
        pol_d[p]  = (|set_i[2*p +: 2]) ? set_i[2*p] : pol_q[p];
      end else if (pend_q[p]) begin
        if (|set_i[2*p +: 2]) begin
          ndrop = ndrop + 1;
        end else begin
          ndrop = ndrop;
        end
      end else if (|set_i[2*p +: 2]) begin
        pend_d[p] = 1'b1;
        pol_d[p]  = set_i[2*p];
      end else begin
        pend_d[p] = 1'b0;
      end
    end
    dsum   = int'(drop_q) + ndrop;
    drop_d = (dsum > 32'sd65535) ? 16'hFFFF : 16'(dsum);
    ts_d   = ts_q + TS_WIDTH'(1'b1);
  end

  always_comb begin
    state_d   = state_q;
    grp_ptr_d = grp_ptr_q;
    cur_grp_d = cur_grp_q;
    pix_ptr_d = pix_ptr_q;
    burst_d   = burst_q;
    case (state_q)
      ST_IDLE: begin
        if (|pend_d) state_d = ST_GSEL;
        else         state_d = ST_IDLE;
      end
      ST_GSEL: begin
        if (grp_found) begin
          cur_grp_d = sel_grp;
          burst_d   = {BW{1'b0}};
          state_d   = ST_SERVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (tenure_end) begin
          grp_ptr_d = (cur_grp_q == GW'(NG - 1)) ? {GW{1'b0}} : cur_grp_q + GW'(1'b1);
          state_d   = ST_GSEL;
        end else if (grant_en) begin
          pix_ptr_d[cur_grp_q] = (sel_pix == LW'(PPG - 1)) ? {LW{1'b0}} : sel_pix + LW'(1'b1);
          burst_d              = burst_q + BW'(1'b1);
        end else begin
          state_d = ST_SERVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    push  = grant_en;
    pop   = !fifo_empty && data_ready_i;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = gnt_word;
    else      mem_d[wr_q] = mem_q[wr_q];
    wr_d  = push ? wr_q + FW'(1'b1) : wr_q;
    rd_d  = pop ? rd_q + FW'(1'b1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      pend_q    <= {NPIX{1'b0}};
      pol_q     <= {NPIX{1'b0}};
      grp_ptr_q <= {GW{1'b0}};
      cur_grp_q <= {GW{1'b0}};
      for (int g = 0; g < NG; g++) pix_ptr_q[g] <= {LW{1'b0}};
      burst_q   <= {BW{1'b0}};
      ts_q      <= {TS_WIDTH{1'b0}};
      drop_q    <= 16'h0000;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= {DW{1'b0}};
      wr_q      <= {FW{1'b0}};
      rd_q      <= {FW{1'b0}};
      cnt_q     <= {CW{1'b0}};
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      pol_q     <= pol_d;
      grp_ptr_q <= grp_ptr_d;
      cur_grp_q <= cur_grp_d;
      pix_ptr_q <= pix_ptr_d;
      burst_q   <= burst_d;
      ts_q      <= ts_d;
      drop_q    <= drop_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt_o         = gnt_vec;
  assign grp_release_o = tenure_end;
  assign data_out_o    = mem_q[rd_q];
  assign data_valid_o  = !fifo_empty;
  assign drop_cnt_o    = drop_q;
  assign busy_o        = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_pix_event_arbiter_rr.sv
// Bench for pix_event_arbiter_rr: directed scenarios plus random traffic, all
// checked cycle by cycle against a row/column based reference model.
module tb_pix_event_arbiter_rr;

  localparam int R = 8, C = 8, G = 4, TSW = 16, DEPTH = 4, MB = 2;
  localparam int NGC = C / G, NG = (R / G) * NGC, PPG = G * G, DW = 3 + 3 + TSW + 1;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [127:0]    set_i;
  logic [63:0]     gnt_o;
  logic            grp_release_o;
  logic [DW-1:0]   data_out_o;
  logic            data_valid_o;
  logic            data_ready_i;
  logic [15:0]     drop_cnt_o;
  logic            busy_o;

  pix_event_arbiter_rr #(
    .ROWS(R), .COLS(C), .GRP(G), .TS_WIDTH(TSW), .FIFO_DEPTH(DEPTH), .MAX_BURST(MB)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .set_i(set_i), .gnt_o(gnt_o),
    .grp_release_o(grp_release_o), .data_out_o(data_out_o), .data_valid_o(data_valid_o),
    .data_ready_i(data_ready_i), .drop_cnt_o(drop_cnt_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: 2-D pixel state, a queue for the FIFO, a countdown quota.
  bit            m_pend [R][C];
  bit            m_pol  [R][C];
  int            m_phase;          // 0 waiting, 1 choosing a group, 2 serving a group
  int            m_grp, m_next_grp, m_left, m_ts, m_drops;
  int            m_next_pix [NG];
  logic [DW-1:0] m_q [$];
  int            e_gnt, e_l;
  bit            e_rel;

  task automatic model_reset();
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) begin
      m_pend[r][c] = 1'b0;
      m_pol[r][c]  = 1'b0;
    end
    for (int g = 0; g < NG; g++) m_next_pix[g] = 0;
    m_phase = 0; m_grp = 0; m_next_grp = 0; m_left = 0; m_ts = 0; m_drops = 0;
    m_q.delete();
  endtask

  function automatic bit grp_has(input int g);
    bit any = 1'b0;
    for (int lr = 0; lr < G; lr++) for (int lc = 0; lc < G; lc++)
      any |= m_pend[(g / NGC) * G + lr][(g % NGC) * G + lc];
    return any;
  endfunction

  task automatic m_decide();
    int l, r, c;
    e_gnt = -1; e_l = 0; e_rel = 1'b0;
    if (m_phase == 2) begin
      if (!grp_has(m_grp) || m_left == 0) e_rel = 1'b1;
      else if (m_q.size() < DEPTH) begin
        for (int k = 0; k < PPG; k++) begin
          l = (m_next_pix[m_grp] + k) % PPG;
          r = (m_grp / NGC) * G + l / G;
          c = (m_grp % NGC) * G + l % G;
          if (e_gnt < 0 && m_pend[r][c]) begin
            e_gnt = r * C + c;
            e_l   = l;
          end
        end
      end
    end
  endtask

  task automatic model_advance(input logic [127:0] s, input bit rdy, input bit rst);
    int chosen, r, c;
    bit any;
    logic [1:0] v;
    if (rst) begin
      model_reset();
      return;
    end
    m_decide();
    chosen = -1;
    if (m_phase == 1)
      for (int k = 0; k < NG; k++)
        if (chosen < 0 && grp_has((m_next_grp + k) % NG)) chosen = (m_next_grp + k) % NG;
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    if (e_gnt >= 0) begin
      r = e_gnt / C; c = e_gnt % C;
      m_q.push_back({3'(r), 3'(c), 16'(m_ts), m_pol[r][c]});
    end
    for (int pr = 0; pr < R; pr++) for (int pc = 0; pc < C; pc++) begin
      v = s[2*(pr*C+pc) +: 2];
      if (pr * C + pc == e_gnt) begin
        m_pend[pr][pc] = (v != 2'b00);
        if (v != 2'b00) m_pol[pr][pc] = v[0];
      end else if (m_pend[pr][pc]) begin
        if (v != 2'b00 && m_drops < 65535) m_drops++;
      end else if (v != 2'b00) begin
        m_pend[pr][pc] = 1'b1;
        m_pol[pr][pc]  = v[0];
      end
    end
    case (m_phase)
      0: begin
        any = 1'b0;
        for (int g = 0; g < NG; g++) any |= grp_has(g);
        if (any) m_phase = 1;
      end
      1: begin
        if (chosen >= 0) begin m_grp = chosen; m_left = MB; m_phase = 2; end
        else m_phase = 0;
      end
      default: begin
        if (e_rel) begin m_next_grp = (m_grp + 1) % NG; m_phase = 1; end
        else if (e_gnt >= 0) begin m_next_pix[m_grp] = (e_l + 1) % PPG; m_left--; end
      end
    endcase
    m_ts = (m_ts + 1) % 65536;
  endtask

  task automatic model_compare();
    logic [63:0] eg;
    m_decide();
    eg = 64'd0;
    if (e_gnt >= 0) eg[e_gnt] = 1'b1;
    chk("gnt", gnt_o, eg);
    chk("release", 64'(grp_release_o), 64'(e_rel));
    chk("valid", 64'(data_valid_o), 64'(m_q.size() > 0));
    if (m_q.size() > 0) chk("data", 64'(data_out_o), 64'(m_q[0]));
    chk("drops", 64'(drop_cnt_o), 64'(m_drops));
    chk("busy", 64'(busy_o), 64'((m_phase != 0) || (m_q.size() > 0)));
  endtask

  task automatic cycle(input logic [127:0] s, input bit rdy, input bit rst);
    set_i = s; data_ready_i = rdy; reset_i = rst;
    model_advance(s, rdy, rst);
    @(posedge clk);
    #1;
    model_compare();
  endtask

  logic [DW-1:0] pq [$];
  int            gq [$];

  function automatic int onehot(input logic [63:0] v);
    int idx = -1;
    for (int i = 63; i >= 0; i--) if (v[i]) idx = i;
    return idx;
  endfunction

  task automatic cyc_rec(input logic [127:0] s, input bit rdy);
    if (data_valid_o && rdy) pq.push_back(data_out_o);
    if (|gnt_o) gq.push_back(onehot(gnt_o));
    cycle(s, rdy, 1'b0);
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc_rec(128'd0, rdy);
  endtask

  function automatic logic [127:0] px(input int r, input int c, input logic [1:0] v);
    logic [127:0] t;
    t = 128'd0;
    t[2*(r*C+c) +: 2] = v;
    return t;
  endfunction

  function automatic int wpix(input logic [DW-1:0] w);
    return int'(w[DW-1 -: 3]) * C + int'(w[DW-4 -: 3]);
  endfunction

  initial begin
    logic [127:0] s;
    int k, gseen, n9, pol9a, pol9b;
    reset_i = 1'b1; set_i = 128'd0; data_ready_i = 1'b0;
    model_reset();

    // reset state and single event at ts=10
    cycle(128'd0, 1'b1, 1'b1);
    chk("rst_gnt", gnt_o, 64'd0);
    chk("rst_valid", 64'(data_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_drop", 64'(drop_cnt_o), 64'd0);
    run(10, 1'b1);
    cycle(px(2, 5, 2'b01), 1'b1, 1'b0);
    cycle(128'd0, 1'b1, 1'b0);
    chk("single_gnt", gnt_o, 64'd1 << 21);
    cycle(128'd0, 1'b1, 1'b0);
    chk("single_word", 64'(data_out_o), 64'({3'd2, 3'd5, 16'd12, 1'b1}));
    chk("single_valid", 64'(data_valid_o), 64'd1);
    chk("single_rel", 64'(grp_release_o), 64'd1);
    chk("single_drop", 64'(drop_cnt_o), 64'd0);

    // group round-robin
    cycle(128'd0, 1'b1, 1'b1);
    gq.delete();
    cycle(px(0, 0, 2'b01) | px(0, 4, 2'b01) | px(4, 0, 2'b10), 1'b1, 1'b0);
    run(15, 1'b1);
    chk("rr_cnt", 64'(gq.size()), 64'd3);
    if (gq.size() >= 3) begin
      chk("rr_0", 64'(gq[0]), 64'd0);
      chk("rr_1", 64'(gq[1]), 64'd4);
      chk("rr_2", 64'(gq[2]), 64'd32);
    end
    gq.delete();
    cyc_rec(px(0, 0, 2'b01) | px(4, 4, 2'b01), 1'b1);
    run(15, 1'b1);
    chk("rr_rep_cnt", 64'(gq.size()), 64'd2);
    if (gq.size() >= 2) begin
      chk("rr_rep_0", 64'(gq[0]), 64'd36);
      chk("rr_rep_1", 64'(gq[1]), 64'd0);
    end

    // burst quota
    cycle(128'd0, 1'b1, 1'b1);
    gq.delete();
    cycle(px(0, 0, 2'b01) | px(0, 1, 2'b01) | px(0, 2, 2'b01) | px(0, 4, 2'b01), 1'b1, 1'b0);
    run(20, 1'b1);
    chk("burst_cnt", 64'(gq.size()), 64'd4);
    if (gq.size() >= 4) begin
      chk("burst_0", 64'(gq[0]), 64'd0);
      chk("burst_1", 64'(gq[1]), 64'd1);
      chk("burst_2", 64'(gq[2]), 64'd4);
      chk("burst_3", 64'(gq[3]), 64'd2);
    end

    // backpressure
    cycle(128'd0, 1'b1, 1'b1);
    gq.delete(); pq.delete();
    cycle(px(0, 0, 2'b01) | px(0, 1, 2'b01) | px(0, 2, 2'b01) | px(0, 4, 2'b01) |
          px(0, 5, 2'b01) | px(4, 0, 2'b01), 1'b0, 1'b0);
    run(20, 1'b0);
    chk("bp_stall_grants", 64'(gq.size()), 64'd4);
    chk("bp_stall_valid", 64'(data_valid_o), 64'd1);
    run(30, 1'b1);
    chk("bp_total_grants", 64'(gq.size()), 64'd6);
    chk("bp_pops", 64'(pq.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      if (i < pq.size() && i < gq.size()) chk("bp_order", 64'(wpix(pq[i])), 64'(gq[i]));

    // drop and re-capture on pixel (1,1)
    cycle(128'd0, 1'b1, 1'b1);
    pq.delete();
    cycle(px(4, 0, 2'b01) | px(4, 1, 2'b01) | px(4, 4, 2'b01) | px(4, 5, 2'b01), 1'b0, 1'b0);
    run(15, 1'b0);
    for (int i = 0; i < 3; i++) cyc_rec(px(1, 1, 2'b10), 1'b0);
    chk("drop_cnt", 64'(drop_cnt_o), 64'd2);
    k = 0;
    while (!gnt_o[9] && k < 40) begin
      cyc_rec(128'd0, 1'b1);
      k++;
    end
    chk("drop_wait_gnt", 64'(gnt_o[9]), 64'd1);
    cyc_rec(px(1, 1, 2'b01), 1'b1);
    run(30, 1'b1);
    n9 = 0; pol9a = -1; pol9b = -1;
    foreach (pq[i]) if (wpix(pq[i]) == 9) begin
      if (n9 == 0) pol9a = int'(pq[i][0]);
      else         pol9b = int'(pq[i][0]);
      n9++;
    end
    chk("recap_words", 64'(n9), 64'd2);
    chk("recap_pol_first", 64'(pol9a), 64'd0);
    chk("recap_pol_second", 64'(pol9b), 64'd1);
    chk("recap_drop", 64'(drop_cnt_o), 64'd2);

    // reset mid-burst
    cycle(128'd0, 1'b1, 1'b1);
    s = 128'd0;
    for (int c = 0; c < 4; c++) s |= px(0, c, 2'b01) | px(1, c, 2'b10);
    cycle(s, 1'b0, 1'b0);
    cyc_rec(px(0, 0, 2'b01), 1'b0);
    gseen = 0;
    for (int i = 0; i < 30 && gseen < 3; i++) begin
      if (|gnt_o) gseen++;
      cyc_rec(128'd0, 1'b0);
    end
    chk("mid_drop_pre", 64'(drop_cnt_o), 64'd1);
    chk("mid_valid_pre", 64'(data_valid_o), 64'd1);
    cycle(128'd0, 1'b1, 1'b1);
    chk("mid_valid", 64'(data_valid_o), 64'd0);
    chk("mid_gnt", gnt_o, 64'd0);
    chk("mid_drop", 64'(drop_cnt_o), 64'd0);
    chk("mid_busy", 64'(busy_o), 64'd0);
    pq.delete();
    cycle(px(3, 3, 2'b01), 1'b1, 1'b0);
    run(6, 1'b1);
    chk("mid_words", 64'(pq.size()), 64'd1);
    if (pq.size() > 0) chk("mid_ts", 64'(pq[0][16:1]), 64'd2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      s = 128'd0;
      for (int p = 0; p < 64; p++)
        if ($urandom_range(0, 31) == 0) s[2*p +: 2] = 2'($urandom_range(1, 3));
      cycle(s, $urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
